wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-cycle wide adder that sequences `N_SLICES` 16-bit additions through one `carry_look_ahead_16bit` instance, chaining the carry between slices. It sits directly upstream of the 16-bit CLA stage. It latches wide operands on a valid/ready handshake, feeds one 16-bit slice per cycle (LSB slice first), and collects the slice sums into a wide result. It is the operand-sequencing front end for area-constrained wide additions and for cycle-count measurements on the Zynq fabric.

## Interface
Parameters:
- `N_SLICES`, default 4: number of 16-bit slices; operand width W = 16*N_SLICES; legal range 1..16.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  operands `a`, `b`, `cin` are valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  W  addend A.
- `b`  input  W  addend B.
- `cin`  input  1  carry into slice 0.
- `out_valid`  output  1  `sum`/`cout` hold a completed result.
- `out_ready`  input  1  downstream consumes the result.
- `sum`  output  W  registered result, A+B+cin modulo 2^W.
- `cout`  output  1  carry out of the top slice.
- `busy`  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b` into operand registers, latch `cin` into the carry register, clear slice index k to 0, and go to RUN.
- RUN:
  - Each cycle, drive the adder with a[16k+15:16k], b[16k+15:16k] and the carry register.
  - At the edge, write the adder sum into sum[16k+15:16k] and its cout into the carry register, then increment k.
  - When k==N_SLICES-1, go to DONE at that edge and load `cout` from the adder cout.
- DONE:
  - `out_valid`=1; `sum` and `cout` are held stable.
  - On `out_ready`=1, go to IDLE.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only at the accept edge, so later changes have no effect.
- `sum` is assembled in place. Slices not yet written keep their previous values during RUN. `sum` is only meaningful when `out_valid`=1.
- Arithmetic: unsigned, modulo 2^W. `cout` is bit W of A+B+cin. There is no signed-overflow flag.
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - state goes to IDLE, the in-flight operation is discarded, and no `out_valid` is produced for it.
  - `sum`=0, `cout`=0, the carry register is 0, k=0.
  - The operand registers are cleared to 0.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `in_ready`=1 (the first cycle after reset release).
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register, with no combinational path from inputs.
- Latency: the accept edge is T0. Slices are written at edges T1..TN (N=N_SLICES). `out_valid` rises after TN, i.e. N cycles after acceptance.
- Result handshake completes at the first edge with `out_valid`&&`out_ready`. `in_ready` rises in the next cycle.
- Minimum initiation interval with `out_ready` tied high: N+2 cycles (1 IDLE, N RUN, 1 DONE).
- Back-pressure: DONE holds indefinitely while `out_ready`=0, and `sum`/`cout` do not change.
- Critical path: one 16-bit CLA plus the carry-register mux. No wide carry chain is combinational.

## Test plan
- Full-width carry ripple, N=4: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1. `out_valid` rises exactly 4 cycles after the accept edge.
- Slice-boundary carry, N=4: a=0x0000_FFFF_0000_FFFF, b=0, cin=1 -> sum=0x0000_FFFF_0001_0000, cout=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid` and pulse `in_valid` with new operands -> `sum`/`cout` stay stable and `in_ready`=0. The new operands are not accepted. On `out_ready`=1, IDLE follows in the next cycle.
- Reset mid-op: assert rst_n=0 for one edge while k=2 -> `out_valid` never rises for that op, and `sum`=0, `cout`=0, `in_ready`=1 afterwards. A following op with a=3, b=4 gives sum=7.
- Throughput: 3 back-to-back ops with `in_valid` and `out_ready` held high, N=4 -> accepts are 6 cycles apart and results are 1+2, 5+6, 0xFFFF+0xFFFF (sum=0x1FFFE, cout=0).
- N_SLICES=1: a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, `out_valid` 1 cycle after accept.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: sequences N_SLICES 16-bit additions through one
// 16-bit carry-look-ahead adder, LSB slice first, chaining the carry in a register.

module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic        grp_p;
  logic        grp_g;
  logic        grp_carry;
  logic        bit_carry;

  assign p = a ^ b;
  assign g = a & b;

  // Four 4-bit groups; the group carry skips ahead using group propagate/generate
  always_comb begin
    c         = '0;
    grp_p     = 1'b0;
    grp_g     = 1'b0;
    grp_carry = cin;
    bit_carry = 1'b0;
    for (int j = 0; j < 4; j++) begin
      grp_p = &p[4*j +: 4];
      grp_g = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      bit_carry = grp_carry;
      for (int i = 0; i < 4; i++) begin
        c[4*j+i]  = bit_carry;
        bit_carry = g[4*j+i] | (p[4*j+i] & bit_carry);
      end
      grp_carry = grp_g | (grp_p & grp_carry);
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_carry;

endmodule

module wide_add_sequencer #(
  parameter int N_SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*N_SLICES-1:0]  a,
  input  logic [16*N_SLICES-1:0]  b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*N_SLICES-1:0]  sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int W   = 16 * N_SLICES;
  localparam int K_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           carry;
  logic [K_W-1:0] k;
  logic           last_slice;
  logic [15:0]    slice_a;
  logic [15:0]    slice_b;
  logic [15:0]    slice_sum;
  logic           slice_cout;

  assign last_slice = (k == K_W'(N_SLICES - 1));
  assign slice_a    = op_a[16*k +: 16];
  assign slice_b    = op_b[16*k +: 16];

  carry_look_ahead_16bit u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last_slice) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // k wraps to 0 after the top slice so the slice select always stays in range
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            k     <= '0;
          end
        end
        RUN: begin
          sum[16*k +: 16] <= slice_sum;
          carry           <= slice_cout;
          k               <= last_slice ? '0 : k + K_W'(1);
          if (last_slice) cout <= slice_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: directed literal cases plus randomized traffic against
// a cycle-level behavioural model of the wide adder.

module tb_wide_add_sequencer;

  localparam int N = 4;
  localparam int W = 16 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic         s_in_valid;
  logic         s_in_ready;
  logic [15:0]  s_a;
  logic [15:0]  s_b;
  logic         s_cin;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [15:0]  s_sum;
  logic         s_cout;
  logic         s_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit       model_ok = 1'b0;
  bit       m_active = 1'b0;
  int       m_age    = 0;
  logic [W:0] m_exp  = '0;
  logic [W:0] m_shown = '0;

  wide_add_sequencer #(.N_SLICES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  wide_add_sequencer #(.N_SLICES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .a         (s_a),
    .b         (s_b),
    .cin       (s_cin),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .sum       (s_sum),
    .cout      (s_cout),
    .busy      (s_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a result appears N cycles after acceptance and stays until consumed
  always @(posedge clk) begin
    if (!rst_n) begin
      model_ok = 1'b1;
      m_active = 1'b0;
      m_age    = 0;
      m_shown  = '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active = 1'b1;
        m_age    = 0;
        m_exp    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
    end else if (m_age == N) begin
      if (out_ready) m_active = 1'b0;
    end else begin
      m_age++;
      if (m_age == N) m_shown = m_exp;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, !m_active});
      checkOutput("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, m_active});
      checkOutput("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, (m_active && m_age == N)});
      if (!m_active || m_age == N) begin
        checkOutput("sum", {1'b0, sum}, {1'b0, m_shown[W-1:0]});
        checkOutput("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, m_shown[W]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    bit accepted;
    int guard;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tc;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 50) begin
      accepted = in_ready;
      step();
      guard++;
    end
    checkOutput("accept_timeout", {{W{1'b0}}, accepted}, 1);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    cin      = 1'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    checkOutput("result_timeout", {{W{1'b0}}, out_valid}, 1);
  endtask

  initial begin
    int lat;
    int acc [3];
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W:0]   te [3];

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_a         = '0;
    s_b         = '0;
    s_cin       = 1'b0;
    s_out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    checkOutput("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
    checkOutput("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
    checkOutput("rst_busy", {{W{1'b0}}, busy}, 0);
    checkOutput("rst_sum", {cout, sum}, 0);

    // Single-slice instance
    s_in_valid = 1'b1;
    s_a        = 16'h8000;
    s_b        = 16'h8000;
    step();
    s_in_valid = 1'b0;
    checkOutput("n1_not_yet", {{W{1'b0}}, s_out_valid}, 0);
    step();
    checkOutput("n1_out_valid", {{W{1'b0}}, s_out_valid}, 1);
    checkOutput("n1_sum", {{(W-15){1'b0}}, s_sum}, 0);
    checkOutput("n1_cout", {{W{1'b0}}, s_cout}, 1);
    step();

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    waitResult(lat);
    checkOutput("ripple_latency", W'(lat), 4);
    checkOutput("ripple_sum", {1'b0, sum}, 0);
    checkOutput("ripple_cout", {{W{1'b0}}, cout}, 1);
    step();

    applyStimulus(64'h0000_FFFF_0000_FFFF, 64'h0, 1'b1);
    waitResult(lat);
    checkOutput("boundary_sum", {1'b0, sum}, 65'h0000_FFFF_0001_0000);
    checkOutput("boundary_cout", {{W{1'b0}}, cout}, 0);
    step();

    out_ready = 1'b0;
    applyStimulus(64'd5, 64'd6, 1'b0);
    waitResult(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 64'd99;
      b        = 64'd1;
      step();
      checkOutput("bp_sum", {cout, sum}, 65'd11);
      checkOutput("bp_in_ready", {{W{1'b0}}, in_ready}, 0);
      checkOutput("bp_out_valid", {{W{1'b0}}, out_valid}, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("bp_idle", {{W{1'b0}}, in_ready}, 1);
    checkOutput("bp_released", {{W{1'b0}}, out_valid}, 0);

    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midrst_sum", {cout, sum}, 0);
    checkOutput("midrst_in_ready", {{W{1'b0}}, in_ready}, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("midrst_no_valid", {{W{1'b0}}, out_valid}, 0);
      step();
    end
    applyStimulus(64'd3, 64'd4, 1'b0);
    waitResult(lat);
    checkOutput("after_rst_sum", {cout, sum}, 65'd7);
    step();

    ta[0] = 64'd1;      tb[0] = 64'd2;      te[0] = 65'd3;
    ta[1] = 64'd5;      tb[1] = 64'd6;      te[1] = 65'd11;
    ta[2] = 64'hFFFF;   tb[2] = 64'hFFFF;   te[2] = 65'h1FFFE;
    in_valid  = 1'b1;
    cin       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int guard;
      a     = ta[i];
      b     = tb[i];
      guard = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      acc[i] = cyc;
      step();
      if (i == 2) in_valid = 1'b0;
      waitResult(lat);
      checkOutput("tput_result", {cout, sum}, te[i]);
    end
    checkOutput("tput_gap01", W'(acc[1] - acc[0]), 6);
    checkOutput("tput_gap12", W'(acc[2] - acc[1]), 6);
    step();

    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = {$urandom, $urandom};
      b         = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      step();
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
